// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results win, loads queue in a
// small FIFO with per-entry live bits and read-address hazard flags.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          aluValid,
  input  logic [4:0]    aluReg,
  input  logic [31:0]   aluData,
  input  logic          ldValid,
  input  logic [4:0]    ldReg,
  input  logic [31:0]   ldData,
  output logic          ldReady,
  input  logic [4:0]    chkReg1,
  input  logic [4:0]    chkReg2,
  output logic          hazard1,
  output logic          hazard2,
  output logic [AW:0]   count,
  output logic          write,
  output logic [4:0]    writeReg,
  output logic [31:0]   writeData
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [4:0]       r_reg  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_occ;

  logic          w_alu;
  logic          w_acc;
  logic          w_push;
  logic          w_pop;
  logic          w_head_live;
  logic          w_push_live;
  logic [AW:0]   w_cnt;
  logic          w_hz1;
  logic          w_hz2;

  assign w_alu       = aluValid & (aluReg != 5'd0);
  assign ldReady     = (r_occ < DEPTH_C);
  assign w_acc       = ldValid & ldReady;
  assign w_push      = w_acc & (ldReg != 5'd0);
  assign w_pop       = ~w_alu & (r_occ != '0);
  assign w_head_live = r_live[r_rp];
  // a load racing a same-register ALU result is already stale
  assign w_push_live = ~(w_alu & (aluReg == ldReg));

  always_comb begin
    w_cnt = '0;
    w_hz1 = 1'b0;
    w_hz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + (AW+1)'(r_live[i]);
      if (r_live[i] && (r_reg[i] == chkReg1))
        w_hz1 = 1'b1;
      if (r_live[i] && (r_reg[i] == chkReg2))
        w_hz2 = 1'b1;
    end
    if (w_acc && (ldReg == chkReg1))
      w_hz1 = 1'b1;
    if (w_acc && (ldReg == chkReg2))
      w_hz2 = 1'b1;
  end

  assign count   = w_cnt;
  assign hazard1 = w_hz1 & (chkReg1 != 5'd0);
  assign hazard2 = w_hz2 & (chkReg2 != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alu && r_live[i] && (r_reg[i] == aluReg))
          r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rp] <= 1'b0;
        r_rp         <= r_rp + AW'(1);
      end
      if (w_push) begin
        r_reg[r_wp]  <= ldReg;
        r_data[r_wp] <= ldData;
        r_live[r_wp] <= w_push_live;
        r_wp         <= r_wp + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write     <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else begin
      unique case (1'b1)
        w_alu: begin
          write     <= 1'b1;
          writeReg  <= aluReg;
          writeData <= aluData;
        end
        (w_pop && w_head_live): begin
          write     <= 1'b1;
          writeReg  <= r_reg[r_rp];
          writeData <= r_data[r_rp];
        end
        default: write <= 1'b0;
      endcase
    end
  end

endmodule
